// File: rtl/ir_command_queue.sv
// NEC IR command front end: frame capture, integrity check, same-key repeat lockout,
// direction/shoot decode and a small FIFO of accepted key codes for the processor.
module ir_command_queue #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 2500000
) (
    input  logic        master_clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [31:0] ir_data,
    input  logic        cmd_read,
    output logic [2:0]  direction,
    output logic        shoot_pulse,
    output logic        cmd_valid,
    output logic [3:0]  cmd_code,
    output logic        fifo_overflow,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = $clog2(HOLDOFF + 1);

    logic          dr_q;
    logic [31:0]   frame_q;
    logic          frame_vld_q;
    logic [3:0]    last_key_q;
    logic          last_key_vld_q, last_key_vld_d;
    logic [3:0]    last_key_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic [2:0]    dir_q, dir_d;
    logic          shoot_q, shoot_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_q, err_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [3:0]    cmd_code_q, cmd_code_d;

    logic [7:0] key, key_n;
    logic       bad, good, repeat_hit, accept;
    logic       empty, full, pop, push_ok, drop;
    logic       capture;

    assign capture = data_ready && !dr_q;

    always_comb begin
        key            = frame_q[23:16];
        key_n          = frame_q[31:24];
        bad            = frame_vld_q && ((key_n != ~key) || (key[7:4] != 4'd0));
        good           = frame_vld_q && !bad;
        repeat_hit     = last_key_vld_q && (key[3:0] == last_key_q) && (holdoff_q != '0);
        accept         = good && !repeat_hit;

        empty          = (wptr_q == rptr_q);
        full           = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        pop            = cmd_read && !empty;
        push_ok        = accept && (!full || pop);
        drop           = accept && full && !pop;
        wptr_d         = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d         = pop ? rptr_q + PW'(1) : rptr_q;

        // Suppressed repeats also reload, so a continuously held key stays locked out.
        holdoff_d      = holdoff_q;
        if (good)
            holdoff_d = HW'(HOLDOFF);
        else if (holdoff_q != '0)
            holdoff_d = holdoff_q - HW'(1);

        last_key_d     = last_key_q;
        last_key_vld_d = last_key_vld_q;
        dir_d          = dir_q;
        shoot_d        = 1'b0;
        if (accept) begin
            last_key_d     = key[3:0];
            last_key_vld_d = 1'b1;
            shoot_d        = (key[3:0] == 4'd5);
            case (key[3:0])
                4'd4:       dir_d = 3'b001;
                4'd6:       dir_d = 3'b010;
                4'd2, 4'd5: dir_d = 3'b100;
                default:    dir_d = dir_q;
            endcase
        end

        ovf_d = ovf_q || drop;
        err_d = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

        // Head bypass covers the entry being written this cycle becoming the new head.
        cmd_valid_d = (wptr_d != rptr_d);
        cmd_code_d  = 4'd0;
        if (cmd_valid_d) begin
            if (push_ok && (wptr_q[AW-1:0] == rptr_d[AW-1:0]))
                cmd_code_d = key[3:0];
            else
                cmd_code_d = mem_q[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            dr_q           <= 1'b0;
            frame_q        <= '0;
            frame_vld_q    <= 1'b0;
            last_key_q     <= '0;
            last_key_vld_q <= 1'b0;
            holdoff_q      <= '0;
            dir_q          <= 3'b100;
            shoot_q        <= 1'b0;
            ovf_q          <= 1'b0;
            err_q          <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_code_q     <= '0;
        end else begin
            dr_q           <= data_ready;
            frame_vld_q    <= capture;
            if (capture)
                frame_q <= ir_data;
            last_key_q     <= last_key_d;
            last_key_vld_q <= last_key_vld_d;
            holdoff_q      <= holdoff_d;
            dir_q          <= dir_d;
            shoot_q        <= shoot_d;
            ovf_q          <= ovf_d;
            err_q          <= err_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_code_q     <= cmd_code_d;
        end
    end

    always_ff @(posedge master_clk) begin
        if (!reset && push_ok)
            mem_q[wptr_q[AW-1:0]] <= key[3:0];
    end

    assign direction     = dir_q;
    assign shoot_pulse   = shoot_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_code      = cmd_code_q;
    assign fifo_overflow = ovf_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_ir_command_queue.sv
// Directed bench for ir_command_queue with a shortened holdoff.
module tb_ir_command_queue;

    localparam int HOLD = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic [31:0] ir_data = '0;
    logic        cmd_read = 1'b0;
    logic [2:0]  direction;
    logic        shoot_pulse;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic        fifo_overflow;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    ir_command_queue #(.FIFO_DEPTH(4), .HOLDOFF(HOLD)) dut (
        .master_clk(clk), .reset(reset), .data_ready(data_ready), .ir_data(ir_data),
        .cmd_read(cmd_read), .direction(direction), .shoot_pulse(shoot_pulse),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .fifo_overflow(fifo_overflow),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; data_ready = 1'b0; cmd_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Ends just after the evaluation edge (E0+1).
    task automatic send_frame(input logic [31:0] d);
        @(negedge clk);
        data_ready = 1'b1; ir_data = d;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(negedge clk);
        cmd_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_read = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (direction !== 3'b100) begin errors++; $display("FAIL reset_dir: got %b expected 100", direction); end
        checks++; if (shoot_pulse !== 1'b0) begin errors++; $display("FAIL reset_shoot: got %b expected 0", shoot_pulse); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
        checks++; if (cmd_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", fifo_overflow); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    endtask

    task automatic test_left();
        do_reset();
        @(negedge clk);
        data_ready = 1'b1; ir_data = 32'hFB04_1234;
        @(posedge clk);
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL left_early_valid: got %b expected 0", cmd_valid); end
        @(negedge clk);
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (direction !== 3'b001) begin errors++; $display("FAIL left_dir: got %b expected 001", direction); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL left_valid: got %b expected 1", cmd_valid); end
        checks++; if (cmd_code !== 4'd4) begin errors++; $display("FAIL left_code: got %0d expected 4", cmd_code); end
        checks++; if (shoot_pulse !== 1'b0) begin errors++; $display("FAIL left_shoot: got %b expected 0", shoot_pulse); end
    endtask

    task automatic test_shoot();
        do_reset();
        send_frame(32'hFB04_0000);
        pop_one();
        send_frame(32'hFA05_ABCD);
        checks++; if (shoot_pulse !== 1'b1) begin errors++; $display("FAIL shoot_high: got %b expected 1", shoot_pulse); end
        checks++; if (direction !== 3'b100) begin errors++; $display("FAIL shoot_dir: got %b expected 100", direction); end
        checks++; if (cmd_code !== 4'd5) begin errors++; $display("FAIL shoot_code: got %0d expected 5", cmd_code); end
        @(posedge clk);
        #1;
        checks++; if (shoot_pulse !== 1'b0) begin errors++; $display("FAIL shoot_low: got %b expected 0", shoot_pulse); end
    endtask

    task automatic test_bad_frames();
        do_reset();
        send_frame(32'hFB04_0000);
        send_frame(32'hFF04_0000);
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_err1: got %0d expected 1", err_count); end
        checks++; if (direction !== 3'b001) begin errors++; $display("FAIL bad_dir: got %b expected 001", direction); end
        checks++; if (cmd_code !== 4'd4) begin errors++; $display("FAIL bad_code: got %0d expected 4", cmd_code); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bad_one_entry: got %b expected 0", cmd_valid); end
        send_frame(32'hEF10_0000);
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL bad_highnib: got %0d expected 2", err_count); end
        for (int i = 0; i < 260; i++) send_frame(32'hFF04_0000);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL bad_saturate: got %0d expected 255", err_count); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bad_no_push: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_repeat();
        do_reset();
        send_frame(32'hF906_0000);
        checks++; if (direction !== 3'b010) begin errors++; $display("FAIL rep_dir: got %b expected 010", direction); end
        repeat (1000) @(posedge clk);
        send_frame(32'hF906_0000);
        repeat (1500) @(posedge clk);
        send_frame(32'hF906_0000);
        repeat (HOLD + 10) @(posedge clk);
        send_frame(32'hF906_0000);
        checks++; if (cmd_code !== 4'd6) begin errors++; $display("FAIL rep_code: got %0d expected 6", cmd_code); end
        pop_one();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rep_second_entry: got %b expected 1", cmd_valid); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rep_two_entries: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd2, 4'd3, 4'd4, 4'd0};
        do_reset();
        send_frame(32'hFE01_0000);
        send_frame(32'hFD02_0000);
        send_frame(32'hFC03_0000);
        send_frame(32'hFB04_0000);
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_flag: got %b expected 0", fifo_overflow); end
        send_frame(32'hF807_0000);
        checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", fifo_overflow); end
        checks++; if (direction !== 3'b001) begin errors++; $display("FAIL ovf_dir: got %b expected 001", direction); end
        checks++; if (cmd_code !== 4'd1) begin errors++; $display("FAIL ovf_head: got %0d expected 1", cmd_code); end
        for (int i = 0; i < 4; i++) begin
            pop_one();
            checks++; if (cmd_code !== exp_codes[i]) begin errors++; $display("FAIL ovf_pop%0d_code: got %0d expected %0d", i, cmd_code, exp_codes[i]); end
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", cmd_valid); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_pop: got %b expected 0", cmd_valid); end
        checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", fifo_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd3, 4'd4, 4'd9, 4'd0};
        do_reset();
        send_frame(32'hFE01_0000);
        send_frame(32'hFD02_0000);
        send_frame(32'hFC03_0000);
        send_frame(32'hFB04_0000);
        @(negedge clk);
        data_ready = 1'b1; ir_data = 32'hF609_0000;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0; cmd_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_read = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %b expected 0", fifo_overflow); end
        checks++; if (cmd_code !== 4'd2) begin errors++; $display("FAIL pp_head: got %0d expected 2", cmd_code); end
        for (int i = 0; i < 4; i++) begin
            pop_one();
            checks++; if (cmd_code !== exp_codes[i]) begin errors++; $display("FAIL pp_pop%0d_code: got %0d expected %0d", i, cmd_code, exp_codes[i]); end
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pp_drained: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); data_ready = 1'b1; ir_data = 32'hFB04_0000;
        @(negedge clk); data_ready = 1'b0;
        @(negedge clk); data_ready = 1'b1; ir_data = 32'hF906_0000;
        @(negedge clk); data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (direction !== 3'b010) begin errors++; $display("FAIL b2b_dir: got %b expected 010", direction); end
        checks++; if (cmd_code !== 4'd4) begin errors++; $display("FAIL b2b_head: got %0d expected 4", cmd_code); end
        pop_one();
        checks++; if (cmd_code !== 4'd6) begin errors++; $display("FAIL b2b_second: got %0d expected 6", cmd_code); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", cmd_valid); end
        do_reset();
        @(negedge clk); data_ready = 1'b1; ir_data = 32'hFE01_0000;
        repeat (10) @(negedge clk) ir_data = 32'hFD02_0000;
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (cmd_code !== 4'd1) begin errors++; $display("FAIL held_code: got %0d expected 1", cmd_code); end
        pop_one();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL held_single: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_reset_holdoff();
        do_reset();
        send_frame(32'hFF04_0000);
        send_frame(32'hF906_0000);
        repeat (20) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (direction !== 3'b100) begin errors++; $display("FAIL rh_dir: got %b expected 100", direction); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b expected 0", cmd_valid); end
        checks++; if (cmd_code !== 4'd0) begin errors++; $display("FAIL rh_code: got %0d expected 0", cmd_code); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rh_err: got %0d expected 0", err_count); end
        @(negedge clk); reset = 1'b0;
        send_frame(32'hF906_0000);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rh_key_after: got %b expected 1", cmd_valid); end
        checks++; if (cmd_code !== 4'd6) begin errors++; $display("FAIL rh_code_after: got %0d expected 6", cmd_code); end
        pop_one();
        @(negedge clk); data_ready = 1'b1; ir_data = 32'hFB04_0000;
        @(posedge clk);
        @(negedge clk); data_ready = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (direction !== 3'b100) begin errors++; $display("FAIL rf_dir: got %b expected 100", direction); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b expected 0", cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_left();
        test_shoot();
        test_bad_frames();
        test_repeat();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_holdoff();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
